// File: rtl/crc_serial_capture.sv
// -----------------------------------------------------------------------------
// crc_serial_capture
//
// Collects the LSB-first serial CRC stream coming out of LFSR_CRC, packs it
// into CRC_WIDTH-bit words and queues them in a small FIFO. The FIFO head is
// presented on a valid/ready interface. Bursts that end before a full word
// produce a one-cycle RUNT pulse. A completed word that finds the FIFO full
// (and no pop that cycle) is dropped and sets the sticky OVERFLOW flag.
//
// Optional build macro: CRC_CAPTURE_CHECK_EN
//   When defined, EXP_CRC is compared against each completed word on the
//   cycle that samples its last bit. The result travels through the FIFO
//   with the word and is presented on MATCH.
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   CRC_IN      serial CRC bit, LSB first
//   VALID_IN    qualifies CRC_IN
//   WORD_OUT    head-of-FIFO CRC word (holds last value when empty)
//   WORD_VALID  FIFO not empty
//   WORD_READY  consumer accepts WORD_OUT when WORD_VALID is high
//   RUNT        one-cycle pulse for a truncated burst
//   OVERFLOW    sticky, a completed word was dropped
//   BIT_CNT     bits collected in the current word
//   EXP_CRC     expected CRC (CRC_CAPTURE_CHECK_EN only)
//   MATCH       head word matched its EXP_CRC (CRC_CAPTURE_CHECK_EN only)
// -----------------------------------------------------------------------------
module crc_serial_capture #(
  parameter int CRC_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CRC_IN,
  input  logic                          VALID_IN,
  output logic [CRC_WIDTH-1:0]          WORD_OUT,
  output logic                          WORD_VALID,
  input  logic                          WORD_READY,
  output logic                          RUNT,
  output logic                          OVERFLOW,
  output logic [$clog2(CRC_WIDTH)-1:0]  BIT_CNT
`ifdef CRC_CAPTURE_CHECK_EN
  ,
  input  logic [CRC_WIDTH-1:0]          EXP_CRC,
  output logic                          MATCH
`endif
);

  localparam int CNT_W = $clog2(CRC_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef CRC_CAPTURE_CHECK_EN
  localparam int ENT_W = CRC_WIDTH + 1;  // match flag rides in the top bit
`else
  localparam int ENT_W = CRC_WIDTH;
`endif

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_SHIFT  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Serial capture
  // ---------------------------------------------------------------------------
  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CRC_WIDTH-1:0] r_shift;
  logic                 r_runt;
  logic                 r_push;
  logic [ENT_W-1:0]     r_push_ent;

  logic                 w_last;
  logic [CRC_WIDTH-1:0] w_word;
  logic [ENT_W-1:0]     w_new_ent;

  assign w_last = (r_state == S_SHIFT) && VALID_IN && (r_cnt == LAST_BIT);
  // The last bit goes straight into the word rather than through r_shift.
  assign w_word = {CRC_IN, r_shift[CRC_WIDTH-2:0]};
`ifdef CRC_CAPTURE_CHECK_EN
  assign w_new_ent = {(w_word == EXP_CRC), w_word};
`else
  assign w_new_ent = w_word;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and the block order cannot change the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_runt     <= 1'b0;
      r_push     <= 1'b0;
      r_push_ent <= '0;
    end else begin
      r_runt <= 1'b0;
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (VALID_IN) begin
            r_shift[0] <= CRC_IN;
            r_cnt      <= CNT_W'(1);
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (VALID_IN) begin
            if (w_last) begin
              // Word complete; a bit on the next cycle starts a fresh word
              // from IDLE, so back-to-back words need no gap cycle.
              r_push     <= 1'b1;
              r_push_ent <= w_new_ent;
              r_cnt      <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_shift[r_cnt] <= CRC_IN;
              r_cnt          <= r_cnt + CNT_W'(1);
            end
          end else begin
            // In SHIFT the count is always 1..CRC_WIDTH-1: a truncated burst.
            r_runt  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO. The push is taken from the registered capture stage, which gives
  // the one-cycle latency from last bit to WORD_VALID.
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [ENT_W-1:0] r_head;
  logic             r_ovf;

  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic [PTR_W-1:0] w_rd_next;

  assign w_pop     = (r_count != '0) && WORD_READY;
  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_wr      = r_push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so clearing the data itself buys nothing.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_ent;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= w_rd_next;
      r_count <= r_count + (PTR_W+1)'(w_wr) - (PTR_W+1)'(w_pop);
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;

      // Registered head: tracks the entry at the read pointer and simply
      // holds when the FIFO drains, so WORD_OUT keeps its last value.
      if (w_pop) begin
        if (r_count >= (PTR_W+1)'(2)) r_head <= r_mem[w_rd_next];
        else if (w_wr)                r_head <= r_push_ent;
      end else if ((r_count == '0) && w_wr) begin
        r_head <= r_push_ent;
      end
    end
  end

  assign WORD_OUT   = r_head[CRC_WIDTH-1:0];
  assign WORD_VALID = (r_count != '0);
  assign RUNT       = r_runt;
  assign OVERFLOW   = r_ovf;
  assign BIT_CNT    = r_cnt;
`ifdef CRC_CAPTURE_CHECK_EN
  assign MATCH      = r_head[CRC_WIDTH];
`endif

endmodule

// File: tb/tb_crc_serial_capture.sv
// -----------------------------------------------------------------------------
// Testbench for crc_serial_capture (CRC_WIDTH=8, FIFO_DEPTH=2).
// A queue-based reference model predicts every output each cycle; a vector
// table and hand-written sequences add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_crc_serial_capture;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = $clog2(W);

  logic          CLK;
  logic          RST;
  logic          CRC_IN;
  logic          VALID_IN;
  logic [W-1:0]  WORD_OUT;
  logic          WORD_VALID;
  logic          WORD_READY;
  logic          RUNT;
  logic          OVERFLOW;
  logic [CW-1:0] BIT_CNT;
`ifdef CRC_CAPTURE_CHECK_EN
  logic [W-1:0]  EXP_CRC;
  logic          MATCH;
`endif

  crc_serial_capture #(.CRC_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CRC_IN     (CRC_IN),
    .VALID_IN   (VALID_IN),
    .WORD_OUT   (WORD_OUT),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .RUNT       (RUNT),
    .OVERFLOW   (OVERFLOW),
    .BIT_CNT    (BIT_CNT)
`ifdef CRC_CAPTURE_CHECK_EN
    ,
    .EXP_CRC    (EXP_CRC),
    .MATCH      (MATCH)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: bits of the current burst, a one-slot pending word, and
  // the FIFO as a queue of {match, word}.
  // ---------------------------------------------------------------------------
  bit           m_bits[$];
  logic [W:0]   m_fifo[$];
  logic         m_pend_v;
  logic [W:0]   m_pend_e;
  logic [W:0]   m_last;
  logic         m_ovf;
  logic         m_runt;
  logic [W-1:0] got[$];

  task automatic model_step(input logic rst, v, b, rdy, input logic [W-1:0] exp);
    logic [W-1:0] w;
    if (rst) begin
      m_bits.delete(); m_fifo.delete();
      m_pend_v = 0; m_pend_e = '0; m_last = '0; m_ovf = 0; m_runt = 0;
      return;
    end
    if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
    if (m_pend_v) begin
      if (m_fifo.size() < D) m_fifo.push_back(m_pend_e);
      else m_ovf = 1'b1;
    end
    if (m_fifo.size() != 0) m_last = m_fifo[0];
    m_pend_v = 0;
    m_runt   = 0;
    if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
`ifdef CRC_CAPTURE_CHECK_EN
        m_pend_e = {(w == exp), w};
`else
        m_pend_e = {1'b0, w};
        if (exp == '1) m_pend_e = {1'b0, w};  // exp unused without the checker
`endif
        m_pend_v = 1;
        m_bits.delete();
      end
    end else if (m_bits.size() != 0) begin
      m_runt = 1;
      m_bits.delete();
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare at negedge.
  task automatic cycle(input logic rst, v, b, rdy, input logic [W-1:0] exp);
    RST = rst; VALID_IN = v; CRC_IN = b; WORD_READY = rdy;
`ifdef CRC_CAPTURE_CHECK_EN
    EXP_CRC = exp;
`endif
    if (!rst && WORD_VALID === 1'b1 && rdy) got.push_back(WORD_OUT);
    @(posedge CLK);
    model_step(rst, v, b, rdy, exp);
    @(negedge CLK);
    check("word_valid", WORD_VALID, (m_fifo.size() != 0));
    check("word_out",   WORD_OUT,   m_last[W-1:0]);
    check("runt",       RUNT,       m_runt);
    check("overflow",   OVERFLOW,   m_ovf);
    check("bit_cnt",    BIT_CNT,    m_bits.size());
`ifdef CRC_CAPTURE_CHECK_EN
    check("match",      MATCH,      m_last[W]);
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic [W-1:0] exp);
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, w[i], rdy, exp);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, '0);
  endtask

  typedef struct {
    logic          rst, v, b, rdy;
    logic          e_valid;
    logic [W-1:0]  e_word;
    logic          e_runt, e_ovf;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [W-1:0] a5;
    logic [4:0]   rb;
    logic [W-1:0] w, e;
    int           len;

    RST = 1'b1; VALID_IN = 1'b0; CRC_IN = 1'b0; WORD_READY = 1'b0;
`ifdef CRC_CAPTURE_CHECK_EN
    EXP_CRC = '0;
`endif

    // Basic capture of A5 followed by a 5-bit runt burst.
    a5 = 8'hA5;
    rb = 5'b01011;
    tbl[0] = '{1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{0, 1, a5[i], 1, 0, 8'h00, 0, 0, CW'((i + 1) % W)};
    tbl[10] = '{0, 0, 0, 1, 1, 8'hA5, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 0, 8'hA5, 0, 0, 0};
    for (int i = 0; i < 5; i++)
      tbl[12+i] = '{0, 1, rb[i], 1, 0, 8'hA5, 0, 0, CW'(i + 1)};
    tbl[17] = '{0, 0, 0, 1, 0, 8'hA5, 1, 0, 0};
    tbl[18] = '{0, 0, 0, 1, 0, 8'hA5, 0, 0, 0};

    @(negedge CLK);
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].rdy, '0);
      check("tbl_valid", WORD_VALID, tbl[i].e_valid);
      check("tbl_word",  WORD_OUT,   tbl[i].e_word);
      check("tbl_runt",  RUNT,       tbl[i].e_runt);
      check("tbl_ovf",   OVERFLOW,   tbl[i].e_ovf);
      check("tbl_cnt",   BIT_CNT,    tbl[i].e_cnt);
    end
    check("basic_count", got.size(), 1);
    if (got.size() >= 1) check("basic_word", got[0], 8'hA5);

    // Clean word after the runt.
    got.delete();
    send_word(8'h5A, 1'b1, '0);
    idle(2, 1'b1);
    check("after_runt_count", got.size(), 1);
    if (got.size() >= 1) check("after_runt_word", got[0], 8'h5A);

    // Back-to-back words.
    got.delete();
    send_word(8'h3C, 1'b1, '0);
    send_word(8'hC3, 1'b1, '0);
    idle(3, 1'b1);
    check("b2b_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("b2b_first",  got[0], 8'h3C);
      check("b2b_second", got[1], 8'hC3);
    end

    // Overflow: third word dropped, flag sticky until reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    send_word(8'h11, 1'b0, '0);
    send_word(8'h22, 1'b0, '0);
    send_word(8'h33, 1'b0, '0);
    idle(2, 1'b0);
    check("ovf_set", OVERFLOW, 1'b1);
    got.delete();
    idle(4, 1'b1);
    check("ovf_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("ovf_first",  got[0], 8'h11);
      check("ovf_second", got[1], 8'h22);
    end
    check("ovf_sticky", OVERFLOW, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("ovf_cleared", OVERFLOW, 1'b0);

    // Full FIFO with a pop on the cycle the new word is pushed.
    send_word(8'h11, 1'b0, '0);
    send_word(8'h22, 1'b0, '0);
    idle(2, 1'b0);
    check("full_valid", WORD_VALID, 1'b1);
    got.delete();
    send_word(8'h44, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("fullpop_no_ovf", OVERFLOW, 1'b0);
    check("fullpop_head",   WORD_OUT, 8'h22);
    idle(3, 1'b1);
    check("fullpop_count", got.size(), 3);
    if (got.size() >= 3) begin
      check("fullpop_w0", got[0], 8'h11);
      check("fullpop_w1", got[1], 8'h22);
      check("fullpop_w2", got[2], 8'h44);
    end

    // Reset mid-word: no runt, partial word discarded.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("rst_mid_cnt", BIT_CNT, 0);
    idle(1, 1'b0);
    check("rst_mid_runt", RUNT, 1'b0);
    send_word(8'hA5, 1'b0, 8'hA5);
    send_word(8'hA5, 1'b0, 8'hA4);
    idle(2, 1'b0);
    check("rst_mid_head", WORD_OUT, 8'hA5);
`ifdef CRC_CAPTURE_CHECK_EN
    check("match_first", MATCH, 1'b1);
    idle(1, 1'b1);
    check("match_second", MATCH, 1'b0);
`endif
    idle(3, 1'b1);

    // Randomized words, runts, gaps, back-pressure and occasional resets.
    for (int n = 0; n < 200; n++) begin
      w   = W'($urandom);
      e   = ($urandom_range(0, 1) == 1) ? w : (w ^ W'($urandom_range(1, 255)));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : W;
      for (int i = 0; i < len; i++)
        cycle(($urandom_range(0, 149) == 0), 1'b1, w[i], 1'($urandom_range(0, 1)), e);
      for (int g = $urandom_range(0, 3); g > 0; g--)
        cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), '0);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/crc_serial_capture.md
Name: crc_serial_capture

Overview:
Downstream stage of LFSR_CRC. Captures the serial CRC bit stream (CRC/Valid), which arrives LSB first, and assembles it into parallel CRC words. Buffers the words in a small FIFO and presents them on a valid/ready interface to the consuming logic, such as a frame checker or a register bank. Flags truncated CRC bursts and buffer overflow.

Parameters:
- CRC_WIDTH, 8: bits per CRC word. Must be at least 2.
- FIFO_DEPTH, 2: number of CRC words buffered. Power of 2, at least 2.

Ports:
- CLK  in  1  Clock. All logic is on the rising edge.
- RST  in  1  Reset. Synchronous, active-high.
- CRC_IN  in  1  Serial CRC bit from LFSR_CRC.CRC, LSB first.
- VALID_IN  in  1  Qualifies CRC_IN. Driven from LFSR_CRC.Valid.
- WORD_OUT  out  CRC_WIDTH  Head-of-FIFO CRC word.
- WORD_VALID  out  1  FIFO is not empty.
- WORD_READY  in  1  Consumer accepts WORD_OUT when WORD_VALID and WORD_READY are both high.
- RUNT  out  1  One-cycle pulse: a burst ended with 1..CRC_WIDTH-1 bits collected.
- OVERFLOW  out  1  Sticky: a completed word was dropped because the FIFO was full.
- BIT_CNT  out  clog2(CRC_WIDTH)  Number of bits collected in the current word (debug).

Behaviour:
- Reset: when RST is high at a clock edge, all of the following clear to 0 on that edge:
  - shift register, bit counter, FSM (to IDLE)
  - FIFO pointers and occupancy count
  - WORD_OUT, WORD_VALID, RUNT, OVERFLOW, BIT_CNT
- Reset mid-word discards the partial word and the FIFO contents. It does not produce a RUNT pulse.
- FSM, IDLE state:
  - VALID_IN=1: sample CRC_IN into bit 0, set counter to 1, go to SHIFT.
- FSM, SHIFT state:
  - VALID_IN=1: sample CRC_IN into bit[counter] and increment the counter.
  - When the sampled bit is bit CRC_WIDTH-1: push the word into the FIFO and clear the counter.
    - If VALID_IN stays high, the next bit starts a new word (back-to-back words, no gap cycle).
    - Otherwise the FSM returns to IDLE.
  - VALID_IN=0 with counter 1..CRC_WIDTH-1: RUNT=1 for one cycle, discard the partial word, return to IDLE.
- Bit order: the first bit of a burst maps to WORD_OUT[0] and the last bit to WORD_OUT[CRC_WIDTH-1].
- Latency: WORD_VALID rises on the clock edge after the edge that sampled the last bit (1 cycle), when the FIFO was empty.
- FIFO ordering and pop:
  - WORD_OUT and WORD_VALID are registered or head-of-FIFO outputs. No combinational path from WORD_READY to WORD_VALID.
  - A pop occurs when WORD_VALID and WORD_READY are both high; the next entry appears on the following cycle.
  - First in, first out.
- FIFO full:
  - Push with no pop: the word is dropped, OVERFLOW is set and holds until RST, and the FIFO contents are unchanged.
  - Push and pop in the same cycle: both are performed, no overflow.
- FIFO empty: WORD_READY is ignored and WORD_OUT holds its last value.
- Pointers wrap modulo FIFO_DEPTH. The occupancy count is clog2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: CRC_CAPTURE_CHECK_EN.
- Defined:
  - Adds ports EXP_CRC (in, CRC_WIDTH) and MATCH (out, 1).
  - EXP_CRC is sampled on the cycle that samples the last bit of each word.
  - A match bit (word == EXP_CRC) is stored in the FIFO alongside the word.
  - MATCH is valid whenever WORD_VALID is high, and is 0 after reset.
- Undefined: the ports, the extra FIFO bit and the comparator are absent. All other behaviour is identical.

Test Plan:
- Basic capture: RST for 2 cycles, WORD_READY=1, then VALID_IN=1 for 8 cycles with CRC_IN = 1,0,1,0,0,1,0,1. Expected: WORD_VALID=1 one cycle after the 8th bit, WORD_OUT=8'hA5, popped the same cycle, RUNT=0, OVERFLOW=0.
- Back-to-back words: VALID_IN held high for 16 cycles, carrying 8'h3C then 8'hC3 LSB first, WORD_READY=1. Expected: two words in order, 3C then C3, 8 cycles apart, no RUNT.
- Runt burst: VALID_IN high for 5 bits, then low. Expected: RUNT pulses for exactly 1 cycle, no word pushed, BIT_CNT returns to 0. A following full 8'h5A burst captures cleanly.
- Overflow: WORD_READY=0, send 8'h11, 8'h22, 8'h33. Expected: OVERFLOW=1 after the third word. Then set WORD_READY=1: only 11 and 22 are delivered, in order, and OVERFLOW stays 1 until RST.
- Full with simultaneous pop: FIFO full (11, 22), WORD_READY pulsed high on the cycle 8'h44 completes. Expected: 11 popped, 44 accepted, OVERFLOW=0, next outputs 22 then 44.
- Reset mid-word, with CRC_CAPTURE_CHECK_EN defined: assert RST after 4 bits; then send 8'hA5 with EXP_CRC=8'hA5 and 8'hA5 with EXP_CRC=8'hA4. Expected: no RUNT from the reset, MATCH=1 for the first word and 0 for the second.
